// File: rtl/mmio_mapper_pkg.sv
// mmio_mapper_pkg: shared FSM encoding, register offsets and status bit positions
package mmio_mapper_pkg;
  typedef enum logic [1:0] {IDLE, RAM_ACC, IO_ACC, TX_WAIT} state_e;
  typedef enum logic {REG_DATA = 1'b0, REG_STATUS = 1'b1} reg_e;
  localparam int STAT_TX_RDY = 0;
  localparam int STAT_RX_AVL = 1;
endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: combinational split of an address into I/O window, channel and register
module mmio_decode
  import mmio_mapper_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int N_UART = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'hBF00
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              is_io_o,
  output logic              is_mapped_o,
  output logic [2:0]        chan_o,
  output logic              is_status_o
);
  assign is_io_o     = addr_i[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4];
  assign chan_o      = addr_i[3:1];
  assign is_status_o = reg_e'(addr_i[0]) == REG_STATUS;
  assign is_mapped_o = is_io_o && (int'(chan_o) < N_UART);
endmodule

// File: rtl/mmio_mapper.sv
// mmio_mapper: CPU access sequencer routing to wait-stated RAM or a small UART register window
module mmio_mapper
  import mmio_mapper_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int N_UART = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'hBF00,
  parameter int RAM_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                ram_oe,
  output logic                ram_we,
  input  logic [8*N_UART-1:0] rx_data,
  input  logic [N_UART-1:0]   rx_valid,
  output logic [N_UART-1:0]   rx_ack,
  output logic [7:0]          tx_data,
  output logic [N_UART-1:0]   tx_start,
  input  logic [N_UART-1:0]   tx_busy
);
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, dec_addr;
  logic [DATA_W-1:0]   wdata_q, rdata_q, rdata_d, io_rdata;
  logic                we_q;
  logic                is_io, is_mapped, is_status, is_data;
  logic [2:0]          chan;
  logic [7:0]          rxv, txb, ack8, start8;
  logic [63:0]         rxd;

  // widen channel vectors to 8 lanes so a 3-bit channel index is always in range
  assign rxv = 8'(rx_valid);
  assign txb = 8'(tx_busy);
  assign rxd = 64'(rx_data);
  // in IDLE the live address picks the next state; afterwards the latched one drives decode
  assign dec_addr = state_q == IDLE ? addr : addr_q;
  assign is_data  = is_mapped && !is_status;

  mmio_decode #(.ADDR_W(ADDR_W), .N_UART(N_UART), .IO_BASE(IO_BASE)) u_dec (
    .addr_i      (dec_addr),
    .is_io_o     (is_io),
    .is_mapped_o (is_mapped),
    .chan_o      (chan),
    .is_status_o (is_status)
  );

  // I/O read value, resolved from the channel inputs of the completing cycle
  always_comb begin
    io_rdata = '0;
    if (is_mapped && is_status) begin
      io_rdata[STAT_TX_RDY] = ~txb[chan];
      io_rdata[STAT_RX_AVL] = rxv[chan];
    end else if (is_mapped && rxv[chan]) begin
      io_rdata = DATA_W'(rxd[{chan, 3'b000} +: 8]);
    end
  end

  // next-state, strobes and completion pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ready   = 1'b0;
    ram_oe  = 1'b0;
    ram_we  = 1'b0;
    ack8    = '0;
    start8  = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) state_d = is_io ? IO_ACC : RAM_ACC;
      end
      RAM_ACC: begin
        ram_oe = ~we_q;
        ram_we = we_q;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(RAM_WAIT)) begin
          ready   = 1'b1;
          state_d = IDLE;
          rdata_d = we_q ? rdata_q : ram_rdata;
        end
      end
      IO_ACC, TX_WAIT: begin
        if (is_data && we_q && txb[chan]) begin
          state_d = TX_WAIT;
        end else begin
          ready   = 1'b1;
          state_d = IDLE;
          rdata_d = we_q ? rdata_q : io_rdata;
          ack8[chan]   = is_data && !we_q && rxv[chan];
          start8[chan] = is_data && we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_ack    = N_UART'(ack8);
  assign tx_start  = N_UART'(start8);
  assign tx_data   = |start8 ? wdata_q[7:0] : 8'h00;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata     = rdata_q;

  // state and request latches; the request is captured only when sampled in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (state_q == IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
      end
    end
  end
endmodule

// File: tb/tb_mmio_mapper.sv
// tb_mmio_mapper: scoreboard bench with a window-arithmetic reference model
module tb_mmio_mapper;
  localparam int RW = 1;
  logic        clk = 1'b0, rst = 1'b0, req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0, wdata = '0, ram_rdata = '0, rx_data = '0;
  logic [1:0]  rx_valid = '0, tx_busy = '0;
  logic [15:0] rdata, ram_addr, ram_wdata;
  logic        ready, ram_oe, ram_we;
  logic [1:0]  rx_ack, tx_start;
  logic [7:0]  tx_data;

  mmio_mapper #(.ADDR_W(16), .DATA_W(16), .N_UART(2), .IO_BASE(16'hBF00), .RAM_WAIT(RW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ready(ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_oe(ram_oe), .ram_we(ram_we), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; bit rd; bit ram;
    logic [15:0] addr, wd, rdata;
    logic [1:0] ack, start;
    logic [7:0] txd;
    int oe, we;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endfunction

  // expected outcome of one access from the address map rules; k = cycle in which tx_busy clears
  function automatic exp_t model(logic w, logic [15:0] a, logic [15:0] d, logic [1:0] rv,
                                 logic [15:0] rd, logic [1:0] bz, logic [15:0] md, int k, int n);
    exp_t e;
    int off, ch;
    bit win;
    win = a >= 16'hBF00 && a <= 16'hBF0F;
    off = int'(a) - 32'hBF00;
    ch = off / 2;
    e.rd = !w; e.ram = !win; e.addr = a; e.wd = d; e.rdata = '0;
    e.ack = '0; e.start = '0; e.txd = '0; e.oe = 0; e.we = 0;
    if (!win) begin
      e.cyc = n + RW + 1;
      e.oe = w ? 0 : RW + 1;
      e.we = w ? RW + 1 : 0;
      e.rdata = md;
    end else begin
      e.cyc = n + 1;
      if (ch < 2) begin
        if (off % 2 == 1) begin
          e.rdata = 16'(rv[ch]) * 16'd2 + 16'(!bz[ch]);
        end else if (w) begin
          e.start = 2'(1 << ch);
          e.txd = d[7:0];
          if (bz[ch]) e.cyc = n + (k < 1 ? 1 : k);
        end else if (rv[ch]) begin
          e.ack = 2'(1 << ch);
          e.rdata = 16'(rd[ch*8 +: 8]);
        end
      end
    end
    return e;
  endfunction

  // called at posedge+1 of a cycle in which the DUT is idle; returns at posedge+1 of the next idle cycle
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] rv,
                       input logic [15:0] rd, input logic [1:0] bz, input logic [15:0] md, input int k);
    exp_t e;
    int n;
    bit done;
    n = cyc;
    e = model(w, a, d, rv, rd, bz, md, k, n);
    q.push_back(e);
    we = w; addr = a; wdata = d; rx_valid = rv; rx_data = rd; tx_busy = bz; ram_rdata = md; req = 1'b1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1;
      else begin
        @(posedge clk); #1;
        if (e.start != 0 && cyc == n + k) tx_busy = '0;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: no ready for addr %0h within 40 cycles", a);
      q.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
    end else begin
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  // monitor: pops the scoreboard on every ready and compares the completion
  initial begin
    exp_t e;
    int oe_c, we_c;
    oe_c = 0; we_c = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        oe_c = 0; we_c = 0;
      end else begin
        oe_c += int'(ram_oe);
        we_c += int'(ram_we);
        if (ready) begin
          chk("strobe_excl", 32'($onehot0({rx_ack, tx_start, ram_oe, ram_we})), 1);
          if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ready: got ready at cycle %0d, expected none", cyc);
          end else begin
            e = q.pop_front();
            chk("latency", cyc, e.cyc);
            chk("rx_ack", rx_ack, e.ack);
            chk("tx_start", tx_start, e.start);
            if (e.start != 0) chk("tx_data", tx_data, e.txd);
            chk("oe_cycles", oe_c, e.oe);
            chk("we_cycles", we_c, e.we);
            if (e.ram) chk("ram_addr", ram_addr, e.addr);
            if (e.ram && !e.rd) chk("ram_wdata", ram_wdata, e.wd);
            oe_c = 0; we_c = 0;
            if (e.rd) begin
              @(posedge clk); #1;
              chk("rdata", rdata, e.rdata);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic w;
    logic [1:0] bz;
    req = 1'b1; addr = 16'hBF01;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_oe", ram_oe, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rx_ack", rx_ack, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    issue(0, 16'h0040, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h1234, 0);
    issue(0, 16'hBF01, 16'h0000, 2'b01, 16'h0000, 2'b00, 16'h0000, 0);
    issue(0, 16'hBF02, 16'h0000, 2'b10, 16'hA500, 2'b00, 16'h0000, 0);
    issue(1, 16'hBF00, 16'h0041, 2'b00, 16'h0000, 2'b01, 16'h0000, 4);
    issue(0, 16'hBF0F, 16'h0000, 2'b11, 16'hFFFF, 2'b00, 16'hFFFF, 0);
    issue(1, 16'hBF05, 16'hFFFF, 2'b11, 16'hFFFF, 2'b00, 16'h0000, 0);
    issue(1, 16'h1000, 16'hBEEF, 2'b00, 16'h0000, 2'b00, 16'h0000, 0);
    // reset in the first RAM cycle must abort the access at once
    we = 1'b0; addr = 16'h0080; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("oe_before_rst", ram_oe, 1);
    #2 rst = 1'b0;
    #1;
    chk("oe_at_rst", ram_oe, 0);
    chk("ready_at_rst", ready, 0);
    @(negedge clk);
    chk("ready_in_rst", ready, 0);
    chk("oe_in_rst", ram_oe, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    issue(0, 16'hBF03, 16'h0000, 2'b10, 16'h0000, 2'b00, 16'h0000, 0);
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      bz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = 16'hBF00 + 16'($urandom_range(0, 15));
      else begin
        a = 16'($urandom);
        if (a[15:4] == 12'hBF0) a = a ^ 16'h8000;
      end
      issue(w, a, 16'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), bz, 16'($urandom),
            $urandom_range(1, 4));
    end
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
